// File: rtl/relu_stream_sequencer.sv
// Byte-to-word sequencer between a UART pair and a 16-bit compute unit:
// assembles MSB-first operands, issues them one at a time, queues results and serializes them back.
module relu_stream_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 17360
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_data,
  output logic                        op_valid,
  output logic [15:0]                 op_data,
  input  logic                        op_ready,
  input  logic                        res_valid,
  input  logic [15:0]                 res_data,
  input  logic                        tx_busy,
  output logic                        tx_en,
  output logic [7:0]                  tx_data,
  input  logic                        clr_status,
  output logic                        overrun,
  output logic                        timeout,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {A_MSB, A_LSB, A_ISSUE, A_WAIT} a_state_e;
  typedef enum logic [1:0] {T_IDLE, T_HI, T_LO} t_state_e;

  a_state_e        a_state_q, a_state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     op_data_q, op_data_d;
  logic            op_valid_q, op_valid_d;
  logic            overrun_q, overrun_d;
  logic            timeout_q, timeout_d;
  logic            set_ovr, set_to;

  t_state_e        t_state_q, t_state_d;
  logic [15:0]     word_q, word_d;
  logic            tx_en_q, tx_en_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            guard_q, guard_d;

  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  // Assembly FSM: one operation in flight; bytes arriving while busy are dropped.
  always_comb begin
    a_state_d = a_state_q;
    timer_d   = timer_q;
    op_data_d = op_data_q;
    set_ovr   = 1'b0;
    set_to    = 1'b0;
    push      = 1'b0;
    case (a_state_q)
      A_MSB: begin
        if (rx_valid) begin
          op_data_d[15:8] = rx_data;
          timer_d         = '0;
          a_state_d       = A_LSB;
        end
      end
      A_LSB: begin
        if (rx_valid) begin
          op_data_d[7:0] = rx_data;
          a_state_d      = A_ISSUE;
        end else if (timer_q == TIMER_LAST) begin
          set_to    = 1'b1;
          a_state_d = A_MSB;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      A_ISSUE: begin
        set_ovr = rx_valid;
        if (op_valid_q && op_ready) a_state_d = A_WAIT;
      end
      A_WAIT: begin
        set_ovr = rx_valid;
        if (res_valid) begin
          push      = 1'b1;
          a_state_d = A_MSB;
        end
      end
      default: a_state_d = A_MSB;
    endcase
  end

  // TX FSM: the guard hides tx_busy for the cycle after each pulse.
  always_comb begin
    t_state_d = t_state_q;
    word_d    = word_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    guard_d   = 1'b0;
    pop       = 1'b0;
    case (t_state_q)
      T_IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          word_d    = mem_q[rptr_q];
          t_state_d = T_HI;
        end
      end
      T_HI: begin
        if (!tx_busy && !guard_q) begin
          tx_en_d   = 1'b1;
          tx_data_d = word_q[15:8];
          guard_d   = 1'b1;
          t_state_d = T_LO;
        end
      end
      T_LO: begin
        if (!tx_busy && !guard_q) begin
          tx_en_d   = 1'b1;
          tx_data_d = word_q[7:0];
          guard_d   = 1'b1;
          t_state_d = T_IDLE;
        end
      end
      default: t_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Issuing only with a free slot guarantees the result can always be pushed.
    op_valid_d = (a_state_d == A_ISSUE) && (count_d < FIFO_FULL);
    overrun_d  = set_ovr | (overrun_q & ~clr_status);
    timeout_d  = set_to  | (timeout_q & ~clr_status);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_state_q  <= A_MSB;
      timer_q    <= '0;
      op_data_q  <= '0;
      op_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      t_state_q  <= T_IDLE;
      word_q     <= '0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      guard_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      a_state_q  <= a_state_d;
      timer_q    <= timer_d;
      op_data_q  <= op_data_d;
      op_valid_q <= op_valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      t_state_q  <= t_state_d;
      word_q     <= word_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      guard_q    <= guard_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= res_data;
  end

  assign op_valid   = op_valid_q;
  assign op_data    = op_data_q;
  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_relu_stream_sequencer.sv
// Directed bench for relu_stream_sequencer with an identity compute stub and a UART busy stub.
module tb_relu_stream_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        op_valid;
  logic [15:0] op_data;
  logic        op_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic [15:0] res_data = 16'h0000;
  logic        tx_busy = 1'b0;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        clr_status = 1'b0;
  logic        overrun;
  logic        timeout;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          res_cnt = 0;
  logic [15:0] res_word = 16'h0000;
  int          busy_cnt = 0;
  int          busy_len = 4;
  logic        hold_busy = 1'b0;
  logic        tx_en_prev = 1'b0;
  int          tx_busy_viol = 0;
  int          tx_double = 0;
  logic [7:0]  txq[$];
  int          txt[$];

  relu_stream_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data), .tx_busy(tx_busy),
    .tx_en(tx_en), .tx_data(tx_data), .clr_status(clr_status),
    .overrun(overrun), .timeout(timeout), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Compute stub returns the operand 3 cycles after accept; UART stub goes busy after each byte.
  always @(negedge clk) begin
    res_valid = 1'b0;
    if (res_cnt != 0) begin
      res_cnt = res_cnt - 1;
      if (res_cnt == 0) begin
        res_valid = 1'b1;
        res_data  = res_word;
      end
    end
    if (resetn && op_valid && op_ready) begin
      res_cnt  = 3;
      res_word = op_data;
    end
    if (tx_en) begin
      if (tx_busy) tx_busy_viol = tx_busy_viol + 1;
      if (tx_en_prev) tx_double = tx_double + 1;
      txq.push_back(tx_data);
      txt.push_back(cyc);
    end
    tx_en_prev = tx_en;
    if (tx_en) busy_cnt = busy_len;
    else if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
    tx_busy = hold_busy || (busy_cnt != 0);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle(2);
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got %b want 0", op_valid); end
    checks++; if (op_data !== 16'h0000) begin errors++; $display("FAIL reset_op_data got %h want 0000", op_data); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en got %b want 0", tx_en); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if ({overrun, timeout} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {overrun, timeout}); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_single_word();
    int ov_cycles;
    op_ready = 1'b1;
    txq.delete(); txt.delete();
    send_byte(8'h3C);
    send_byte(8'h00);
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL single_op_valid got %b want 1", op_valid); end
    checks++; if (op_data !== 16'h3C00) begin errors++; $display("FAIL single_op_data got %h want 3c00", op_data); end
    ov_cycles = 1;
    repeat (8) begin
      idle(1);
      if (op_valid) ov_cycles++;
    end
    checks++; if (ov_cycles != 1) begin errors++; $display("FAIL single_op_valid_width got %0d want 1", ov_cycles); end
    idle(30);
    checks++; if (txq.size() != 2) begin errors++; $display("FAIL single_tx_count got %0d want 2", txq.size()); end
    checks++; if (txq.size() >= 2 && (txq[0] !== 8'h3C || txq[1] !== 8'h00)) begin
      errors++; $display("FAIL single_tx_bytes got %h %h want 3c 00", txq[0], txq[1]);
    end
    checks++; if (tx_busy_viol != 0 || tx_double != 0) begin
      errors++; $display("FAIL single_tx_protocol got busy_viol=%0d double=%0d want 0 0", tx_busy_viol, tx_double);
    end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_fifo_empty got %0d want 0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    busy_len = 0;
    txq.delete(); txt.delete();
    send_byte(8'h13);
    send_byte(8'h57);
    idle(20);
    checks++; if (txq.size() != 2) begin errors++; $display("FAIL b2b_tx_count got %0d want 2", txq.size()); end
    else begin
      checks++; if (txq[0] !== 8'h13 || txq[1] !== 8'h57) begin errors++; $display("FAIL b2b_tx_bytes got %h %h want 13 57", txq[0], txq[1]); end
      checks++; if (txt[1] - txt[0] != 2) begin errors++; $display("FAIL b2b_spacing got %0d want 2", txt[1] - txt[0]); end
    end
    busy_len = 4;
    idle(4);
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp_b;
    hold_busy = 1'b1;
    op_ready  = 1'b1;
    idle(2);
    txq.delete(); txt.delete();
    for (int w = 1; w <= 6; w++) begin
      send_byte(8'h00);
      idle(11);
      send_byte(w[7:0]);
      if (w < 6) idle(11);
    end
    // Word 1 sits in the TX word register, words 2..5 fill the FIFO, word 6 must wait.
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_fifo_count got %0d want 4", fifo_count); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL full_op_valid_held got %b want 0", op_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_overrun_pre got %b want 0", overrun); end
    idle(2);
    send_byte(8'hAA);
    idle(1);
    send_byte(8'hBB);
    idle(1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL full_overrun got %b want 1", overrun); end
    checks++; if (op_data !== 16'h0006) begin errors++; $display("FAIL full_op_data_kept got %h want 0006", op_data); end
    hold_busy = 1'b0;
    idle(250);
    checks++; if (txq.size() != 12) begin errors++; $display("FAIL full_tx_count got %0d want 12", txq.size()); end
    for (int i = 0; i < 12; i++) begin
      exp_b = (i % 2 == 0) ? 8'h00 : 8'((i / 2) + 1);
      checks++;
      if (i >= txq.size()) begin errors++; $display("FAIL full_tx_byte%0d got none want %h", i, exp_b); end
      else if (txq[i] !== exp_b) begin errors++; $display("FAIL full_tx_byte%0d got %h want %h", i, txq[i], exp_b); end
    end
    checks++; if (tx_busy_viol != 0 || tx_double != 0) begin
      errors++; $display("FAIL full_tx_protocol got busy_viol=%0d double=%0d want 0 0", tx_busy_viol, tx_double);
    end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL full_drained got %0d want 0", fifo_count); end
    clr_status = 1'b1;
    idle(1);
    clr_status = 1'b0;
  endtask

  task automatic test_timeout();
    send_byte(8'hBC);
    idle(TMO - 1);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", timeout); end
    idle(1);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_set got %b want 1", timeout); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL timeout_no_op got %b want 0", op_valid); end
    send_byte(8'h12);
    send_byte(8'h34);
    checks++; if (op_valid !== 1'b1 || op_data !== 16'h1234) begin
      errors++; $display("FAIL timeout_next_word got v=%b %h want v=1 1234", op_valid, op_data);
    end
    idle(30);
  endtask

  task automatic test_flags();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL flags_timeout_pre got %b want 1", timeout); end
    op_ready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    checks++; if (op_valid !== 1'b1 || op_data !== 16'h1122) begin
      errors++; $display("FAIL flags_issue got v=%b %h want v=1 1122", op_valid, op_data);
    end
    rx_valid = 1'b1; rx_data = 8'h99; clr_status = 1'b1;
    idle(1);
    rx_valid = 1'b0; clr_status = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL flags_set_wins got %b want 1", overrun); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL flags_timeout_clr got %b want 0", timeout); end
    clr_status = 1'b1;
    idle(1);
    clr_status = 1'b0;
    checks++; if (overrun !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL flags_clear got ovr=%b to=%b want 0 0", overrun, timeout);
    end
    op_ready = 1'b1;
    idle(30);
  endtask

  task automatic test_timeout_boundary();
    send_byte(8'h56);
    idle(TMO - 2);
    send_byte(8'h78);
    checks++; if (op_valid !== 1'b1 || op_data !== 16'h5678) begin
      errors++; $display("FAIL boundary_word got v=%b %h want v=1 5678", op_valid, op_data);
    end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL boundary_timeout got %b want 0", timeout); end
    idle(30);
  endtask

  task automatic test_reset_mid_op();
    hold_busy = 1'b1;
    op_ready  = 1'b1;
    idle(2);
    for (int w = 1; w <= 3; w++) begin
      send_byte(8'hA0 + w[7:0]);
      send_byte(w[7:0]);
      idle(8);
    end
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rmid_fifo_pre got %0d want 2", fifo_count); end
    send_byte(8'hA4);
    send_byte(8'h04);
    idle(1);
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL rmid_in_wait got %b want 0", op_valid); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (op_valid !== 1'b0 || op_data !== 16'h0000) begin
      errors++; $display("FAIL rmid_async_op got v=%b %h want v=0 0000", op_valid, op_data);
    end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_async_fifo got %0d want 0", fifo_count); end
    checks++; if (tx_en !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL rmid_async_tx got en=%b %h want en=0 00", tx_en, tx_data);
    end
    idle(1);
    resetn = 1'b1;
    idle(6);
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_late_result got %0d want 0", fifo_count); end
    hold_busy = 1'b0;
    txq.delete(); txt.delete();
    send_byte(8'hAB);
    send_byte(8'hCD);
    idle(40);
    checks++; if (txq.size() != 2) begin errors++; $display("FAIL rmid_tx_count got %0d want 2", txq.size()); end
    else begin
      checks++; if (txq[0] !== 8'hAB || txq[1] !== 8'hCD) begin errors++; $display("FAIL rmid_tx_bytes got %h %h want ab cd", txq[0], txq[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_fifo_full();
    test_timeout();
    test_flags();
    test_timeout_boundary();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
